// File: rtl/sharedmem_frame_reader.sv
// sharedmem_frame_reader: read-side controller for the shared-memory unit RAM.
// On a start pulse it walks frame_len consecutive RAM addresses from a
// captured base address. The addresses wrap modulo the RAM depth. Each word
// is presented on a registered valid/ready stream, and the final word is
// flagged with m_last.
// Optional build macro SHAREDMEM_READER_OVERRUN_CNT_EN adds an 8-bit
// saturating overrun_count output.
`timescale 1ns/1ps

module sharedmem_frame_reader #(
    parameter int word_width    = 4,
    parameter int address_width = 3,
    parameter int frame_len     = 2**address_width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [address_width-1:0] base_addr,
    output logic [address_width-1:0] rd_address,
    input  logic [word_width-1:0]    rd_data,
    output logic [word_width-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
    output logic [7:0]               overrun_count,
`endif
    output logic                     overrun
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Issue counter is one bit wider than the address so it can reach frame_len.
    localparam logic [address_width:0] LEN_C  = (address_width+1)'(frame_len);
    localparam logic [address_width:0] LAST_C = (address_width+1)'(frame_len - 1);

    state_t                   state_q;
    logic [address_width-1:0] base_q;
    logic [address_width:0]   issued_q;
    logic [address_width:0]   issued_d;
    logic [word_width-1:0]    m_data_q;
    logic                     m_valid_q;
    logic                     m_last_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     overrun_q;

    logic load;
    logic final_hs;
    logic start_while_busy;

    // A new word is fetched whenever the output register is empty or drains this cycle.
    assign load             = (state_q == ST_STREAM) && (!m_valid_q || m_ready) && (issued_q < LEN_C);
    assign final_hs         = (state_q == ST_STREAM) && m_valid_q && m_ready && m_last_q;
    assign start_while_busy = (state_q == ST_STREAM) && start;
    assign issued_d         = issued_q + 1'b1;

    // Address arithmetic truncates to address_width, which gives the wrap past the top of RAM.
    assign rd_address = base_q + issued_q[address_width-1:0];

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

    // Frame FSM with registered stream, status and pulse outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            issued_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= start_while_busy;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        m_data_q  <= rd_data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (issued_q == LAST_C);
                        issued_q  <= issued_d;
                    end else if (m_valid_q && m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                    end
                    // The final handshake never coincides with a load, because the counter has reached frame_len.
                    if (final_hs) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    // Saturating count of start requests rejected while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
        end else if (start_while_busy && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sharedmem_frame_reader.sv
// Testbench for sharedmem_frame_reader. It uses scoreboard checking against a
// frame-level reference model. A second instance is built with frame_len=1.
`timescale 1ns/1ps

module tb_sharedmem_frame_reader;

    localparam int WW = 4;
    localparam int AW = 3;
    localparam int L  = 8;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] rd_address;
    logic [WW-1:0] rd_data;
    logic [WW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          overrun;

    logic          start1 = 1'b0;
    logic [AW-1:0] base_addr1 = '0;
    logic [AW-1:0] rd_address1;
    logic [WW-1:0] rd_data1;
    logic [WW-1:0] m_data1;
    logic          m_valid1;
    logic          m_last1;
    logic          busy1;
    logic          done1;
    logic          overrun1;
`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
    logic [7:0]    overrun_count;
    logic [7:0]    overrun_count1;
`endif

    logic [WW-1:0] ram  [DEPTH];
    logic [WW-1:0] ram1 [DEPTH];

    assign rd_data  = ram[rd_address];
    assign rd_data1 = ram1[rd_address1];

    sharedmem_frame_reader #(.word_width(WW), .address_width(AW), .frame_len(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .rd_address(rd_address), .rd_data(rd_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done),
`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
        .overrun_count(overrun_count),
`endif
        .overrun(overrun)
    );

    sharedmem_frame_reader #(.word_width(WW), .address_width(AW), .frame_len(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base_addr1),
        .rd_address(rd_address1), .rd_data(rd_data1), .m_data(m_data1),
        .m_valid(m_valid1), .m_ready(1'b1), .m_last(m_last1),
        .busy(busy1), .done(done1),
`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
        .overrun_count(overrun_count1),
`endif
        .overrun(overrun1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: expected words {last, data} and expected status.
    logic [WW:0] exp_q[$];
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_ovr  = 1'b0;
    int          ovr_cnt  = 0;
    int          pops     = 0;

    // Ready driver modes: 0 = driven by the test, 1 = 1,0,0 pattern, 2 = random.
    int          ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        ovr_cnt  = 0;
        pops     = 0;
    endtask

    // Automatic m_ready generation.
    initial begin : ready_gen
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                m_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end else if (ready_mode == 2) begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: samples at the falling edge and checks against the model.
    // It then advances the model for the coming rising edge.
    initial begin : monitor
        logic          prev_stall = 1'b0;
        logic [WW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        logic [AW-1:0] prev_addr  = '0;
        logic          cur_busy;
        logic [WW:0]   w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                check("busy", 32'(busy), 32'(exp_busy));
                check("done", 32'(done), 32'(exp_done));
                check("overrun", 32'(overrun), 32'(exp_ovr));
`ifdef SHAREDMEM_READER_OVERRUN_CNT_EN
                check("overrun_count", 32'(overrun_count), 32'((ovr_cnt > 255) ? 255 : ovr_cnt));
`endif
                if (!exp_busy) check("valid_while_idle", 32'(m_valid), 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", 32'(m_data), 32'(prev_data));
                    check("stall_last", 32'(m_last), 32'(prev_last));
                    check("stall_addr", 32'(rd_address), 32'(prev_addr));
                end
                cur_busy = exp_busy;
                exp_done = 1'b0;
                exp_ovr  = 1'b0;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check("m_data", 32'(m_data), 32'(w[WW-1:0]));
                        check("m_last", 32'(m_last), 32'(w[WW]));
                        pops++;
                        if (w[WW]) begin
                            exp_busy = 1'b0;
                            exp_done = 1'b1;
                        end
                    end
                end
                if (start) begin
                    if (cur_busy) begin
                        exp_ovr = 1'b1;
                        ovr_cnt++;
                    end else begin
                        for (int i = 0; i < L; i++) begin
                            exp_q.push_back({(i == L-1), ram[(int'(base_addr) + i) % DEPTH]});
                        end
                        exp_busy = 1'b1;
                        pops = 0;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_addr  = rd_address;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!exp_busy && exp_q.size() == 0) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (pops >= n) return;
        end
        check("pops_timeout", 32'd1, 32'd0);
    endtask

    task automatic fill_ram_incr();
        for (int i = 0; i < DEPTH; i++) ram[i] = WW'(i + 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        fill_ram_incr();
        for (int i = 0; i < DEPTH; i++) ram1[i] = WW'(i + 1);
        #13;
        // Reset state.
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_address", 32'(rd_address), 32'd0);
        #9;
        rst_n = 1'b1;

        // Base 0 at full throughput, with latency checks.
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            if (k == 1) check("lat_valid_low", 32'(m_valid), 32'd0);
            if (k == 2) check("lat_first_word", 32'({m_valid, m_data}), 32'({1'b1, 4'd1}));
            if (k == L + 1) check("lat_done_early", 32'(done), 32'd0);
            if (k == L + 2) check("lat_done", 32'(done), 32'd1);
        end
        wait_idle();

        // Base 6: the frame wraps past the top of RAM.
        do_start(3'd6);
        wait_idle();

        // Backpressure with the 1,0,0 ready pattern.
        ready_mode = 1;
        do_start(3'd3);
        wait_idle();
        ready_mode = 0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;

        // Start at word 3 and again in the final-handshake cycle.
        do_start(3'd0);
        wait_pops(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_valid && m_last) break;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("two_overruns", 32'(ovr_cnt), 32'd2);
        wait_idle();
        repeat (4) @(negedge clk);

        // 300 overruns during a stalled frame to exercise saturation.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        do_start(3'd1);
        start = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        start = 1'b0;
        m_ready = 1'b1;
        wait_idle();

        // Reset mid-frame.
        do_start(3'd0);
        wait_pops(4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_outputs", 32'({m_data, m_valid, m_last, busy, done, overrun}), 32'd0);
        check("mid_rst_rd_address", 32'(rd_address), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_start(3'd2);
        wait_idle();

        // frame_len=1 instance.
        @(posedge clk);
        #1;
        start1 = 1'b1;
        base_addr1 = 3'd5;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        check("fl1_valid_low", 32'(m_valid1), 32'd0);
        @(negedge clk);
        check("fl1_word", 32'({m_valid1, m_last1, m_data1}), 32'({1'b1, 1'b1, ram1[5]}));
        @(negedge clk);
        check("fl1_done", 32'({done1, busy1, m_valid1}), 32'({1'b1, 1'b0, 1'b0}));

        // Randomized frames.
        ready_mode = 2;
        for (int f = 0; f < 25; f++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < DEPTH; i++) ram[i] = WW'($urandom_range(0, 15));
            do_start(AW'($urandom_range(0, DEPTH - 1)));
            for (int c = 0; c < 300; c++) begin
                @(posedge clk);
                #1;
                if (!exp_busy) break;
                start = ($urandom_range(0, 9) == 0);
            end
            start = 1'b0;
            wait_idle();
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
